// File: rtl/pool_stream_sequencer.sv
// Streaming KxK, stride-K pooling sequencer over channel-major raster pixel frames.
// Max pooling by default; define POOL_AVG_EN for average pooling (power-of-two KERNEL_SIZE only).
module pool_stream_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int IMG_WIDTH      = 8,
  parameter int IMG_HEIGHT     = 8,
  parameter int KERNEL_SIZE    = 2,
  parameter int INPUT_CHANNELS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OW    = IMG_WIDTH / KERNEL_SIZE;
  localparam int OH    = IMG_HEIGHT / KERNEL_SIZE;
  localparam int BUF_N = (OW > 0) ? OW : 1;
`ifdef POOL_AVG_EN
  localparam int LOG2K = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 0;
  localparam int SHIFT = 2 * LOG2K;
`else
  localparam int SHIFT = 0;
`endif
  localparam int ACC_W = DATA_WIDTH + SHIFT;
  localparam int COL_W = cnt_w(IMG_WIDTH);
  localparam int ROW_W = cnt_w(IMG_HEIGHT);
  localparam int CH_W  = cnt_w(INPUT_CHANNELS);
  localparam int K_W   = cnt_w(KERNEL_SIZE);
  localparam int W_W   = cnt_w(OW + 1);
  localparam int WR_W  = cnt_w(OH + 1);
  localparam int IDX_W = cnt_w(BUF_N);

  generate
    if (KERNEL_SIZE < 1) begin : g_bad_kernel
      $error("pool_stream_sequencer: KERNEL_SIZE must be >= 1");
    end
`ifdef POOL_AVG_EN
    if ((1 << LOG2K) != KERNEL_SIZE) begin : g_bad_avg_kernel
      $error("pool_stream_sequencer: average pooling needs a power-of-two KERNEL_SIZE");
    end
`endif
  endgenerate

  // Window reduction: running max, or running sum for average pooling.
  function automatic logic [ACC_W-1:0] combine(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
`ifdef POOL_AVG_EN
    return a + b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [K_W-1:0]          kc_q, kc_d, kr_q, kr_d;
  logic [W_W-1:0]          w_q, w_d;
  logic [WR_W-1:0]         wr_q, wr_d;
  logic [ACC_W-1:0]        hacc_q, hacc_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;

  logic [ACC_W-1:0]        row_buf [BUF_N];
  logic [IDX_W-1:0]        buf_idx;
  logic [ACC_W-1:0]        buf_rd, pix_ext, hsum, vsum;
  logic                    accept, drain, win_valid, win_end, out_load;
  logic                    last_col, last_row, last_ch;

  assign in_ready  = (state_q == S_RUN) && !(out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;
  assign last_col  = (col_q == COL_W'(IMG_WIDTH - 1));
  assign last_row  = (row_q == ROW_W'(IMG_HEIGHT - 1));
  assign last_ch   = (ch_q == CH_W'(INPUT_CHANNELS - 1));
  // Remainder columns/rows push w/wr to OW/OH, which keeps them out of buf and the output.
  assign win_valid = (w_q < W_W'(OW)) && (wr_q < WR_W'(OH));
  assign win_end   = accept && win_valid && (kc_q == K_W'(KERNEL_SIZE - 1));
  assign out_load  = win_end && (kr_q == K_W'(KERNEL_SIZE - 1));

  assign buf_idx = IDX_W'(w_q);
  assign buf_rd  = row_buf[buf_idx];
  assign pix_ext = ACC_W'(in_data);
  assign hsum    = (kc_q == '0) ? pix_ext : combine(hacc_q, pix_ext);
  assign vsum    = (kr_q == '0) ? hsum : combine(buf_rd, hsum);

  // NOTE: every signal gets a default at the top of the block so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    ch_d        = ch_q;
    kc_d        = kc_q;
    kr_d        = kr_q;
    w_d         = w_q;
    wr_d        = wr_q;
    hacc_d      = hacc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
          ch_d    = '0;
          kc_d    = '0;
          kr_d    = '0;
          w_d     = '0;
          wr_d    = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          hacc_d = hsum;
          if (last_col) begin
            col_d = '0;
            kc_d  = '0;
            w_d   = '0;
            if (last_row) begin
              row_d = '0;
              kr_d  = '0;
              wr_d  = '0;
              if (last_ch) begin
                ch_d    = '0;
                state_d = S_FLUSH;
              end else begin
                ch_d = ch_q + 1'b1;
              end
            end else begin
              row_d = row_q + 1'b1;
              if (kr_q == K_W'(KERNEL_SIZE - 1)) begin
                kr_d = '0;
                wr_d = wr_q + 1'b1;
              end else begin
                kr_d = kr_q + 1'b1;
              end
            end
          end else begin
            col_d = col_q + 1'b1;
            if (kc_q == K_W'(KERNEL_SIZE - 1)) begin
              kc_d = '0;
              w_d  = w_q + 1'b1;
            end else begin
              kc_d = kc_q + 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        if (!out_valid_q || out_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A load in the same cycle as a drain keeps the register full with the new window.
    if (out_load) begin
      out_valid_d = 1'b1;
      out_data_d  = DATA_WIDTH'(vsum >> SHIFT);
      out_last_d  = last_ch && (wr_q == WR_W'(OH - 1)) && (w_q == W_W'(OW - 1));
    end else if (drain) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      kc_q        <= '0;
      kr_q        <= '0;
      w_q         <= '0;
      wr_q        <= '0;
      hacc_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      kc_q        <= kc_d;
      kr_q        <= kr_d;
      w_q         <= w_d;
      wr_q        <= wr_d;
      hacc_q      <= hacc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // NOTE: the row buffer has no reset; each entry is written at kr==0 before it is ever read.
  always_ff @(posedge clk) begin
    if (win_end) row_buf[buf_idx] <= vsum;
  end

  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pool_stream_sequencer.sv
// Self-checking bench for pool_stream_sequencer: table vectors, reset-abort sequence and
// randomized frames against a window-level pooling model (max, or average under POOL_AVG_EN).
module tb_pool_stream_sequencer;

  localparam int DW   = 8;
  localparam int NDUT = 4;
  localparam int CFG_W [NDUT] = '{4, 5, 4, 3};
  localparam int CFG_H [NDUT] = '{4, 5, 4, 3};
  localparam int CFG_K [NDUT] = '{2, 2, 2, 1};
  localparam int CFG_C [NDUT] = '{1, 1, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NDUT-1:0] start_v;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            out_ready;
  logic [NDUT-1:0] busy_v, done_v, in_ready_v, out_valid_v, out_last_v;
  logic [DW-1:0]   out_data_v [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    pool_stream_sequencer #(
      .DATA_WIDTH(DW), .IMG_WIDTH(CFG_W[g]), .IMG_HEIGHT(CFG_H[g]),
      .KERNEL_SIZE(CFG_K[g]), .INPUT_CHANNELS(CFG_C[g])
    ) u_dut (
      .clk(clk), .rst(rst), .start(start_v[g]), .busy(busy_v[g]), .done(done_v[g]),
      .in_valid(in_valid), .in_ready(in_ready_v[g]), .in_data(in_data),
      .out_valid(out_valid_v[g]), .out_ready(out_ready), .out_data(out_data_v[g]),
      .out_last(out_last_v[g])
    );
  end

  logic [1:0]    sel;
  logic          busy, done, in_ready, out_valid, out_last;
  logic [DW-1:0] out_data;
  assign busy      = busy_v[sel];
  assign done      = done_v[sel];
  assign in_ready  = in_ready_v[sel];
  assign out_valid = out_valid_v[sel];
  assign out_last  = out_last_v[sel];
  assign out_data  = out_data_v[sel];

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] pix_q [$];
  logic [DW:0]   got_q [$];
  logic [DW:0]   exp_q [$];

  typedef struct packed {
    logic [1:0]      sel;
    logic [1:0]      pat;
    logic [7:0]      stall;
    logic [3:0]      n_exp;
    logic [7:0][8:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int s, input int p, input int st, input int n,
                              input logic [8:0] e0, e1, e2, e3, e4, e5, e6, e7);
    vec_t v;
    v.sel    = 2'(s);
    v.pat    = 2'(p);
    v.stall  = 8'(st);
    v.n_exp  = 4'(n);
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.exp[4] = e4; v.exp[5] = e5; v.exp[6] = e6; v.exp[7] = e7;
    return v;
  endfunction

  // pat 0: ramp 0,1,2..; pat 1: channel 0 all 0xFF, later channels 0x00; pat 2: random.
  task automatic fill_pix(input int s, input int pat);
    int n = CFG_W[s] * CFG_H[s] * CFG_C[s];
    pix_q.delete();
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       pix_q.push_back(DW'(i));
        1:       pix_q.push_back((i < CFG_W[s] * CFG_H[s]) ? 8'hFF : 8'h00);
        default: pix_q.push_back(DW'($urandom_range(0, 255)));
      endcase
    end
  endtask

  // Reference: walk every complete window of every channel and reduce it directly.
  task automatic model(input int s);
    int w = CFG_W[s];
    int h = CFG_H[s];
    int k = CFG_K[s];
    int c = CFG_C[s];
    int ow = w / k;
    int oh = h / k;
    exp_q.delete();
    for (int ch = 0; ch < c; ch++)
      for (int wr = 0; wr < oh; wr++)
        for (int wc = 0; wc < ow; wc++) begin
          int acc = 0;
          for (int dr = 0; dr < k; dr++)
            for (int dc = 0; dc < k; dc++) begin
              int p = int'(pix_q[ch * w * h + (wr * k + dr) * w + wc * k + dc]);
`ifdef POOL_AVG_EN
              acc += p;
`else
              if (p > acc) acc = p;
`endif
            end
`ifdef POOL_AVG_EN
          acc = acc / (k * k);
`endif
          exp_q.push_back({(ch == c - 1 && wr == oh - 1 && wc == ow - 1), DW'(acc)});
        end
  endtask

  // Drives one frame into DUT s, collects handshaken outputs into got_q and checks protocol timing.
  task automatic run_frame(input int s, input int stall, input bit rnd);
    int n = CFG_W[s] * CFG_H[s] * CFG_C[s];
    int idx = 0, cyc = 0, last_hs = -10, last_acc = -10, stall_left = stall;
    bit first_ov = 1'b0, done_seen = 1'b0, hold = 1'b0;
    logic [DW:0] held = '0;
    got_q.delete();
    sel = 2'(s);
    @(negedge clk);
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v = '0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!done_seen && cyc < 4000) begin
      start_v = '0;
      if (cyc == 3) start_v[s] = 1'b1;
      if (stall > 0 && out_valid) first_ov = 1'b1;
      if (first_ov && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      in_valid = (idx < n) && (!rnd || $urandom_range(0, 4) != 0);
      in_data  = (idx < n) ? pix_q[idx] : '0;
      #1;
      if (done) begin
        int a = (last_acc + 1 > last_hs) ? last_acc + 1 : last_hs;
        done_seen = 1'b1;
        check("done_timing", 32'(cyc), 32'(a + 1));
      end
      if (hold) check("hold_out", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, held});
      hold = out_valid && !out_ready;
      if (hold) begin
        held = {out_last, out_data};
        check("in_ready_stall", 32'(in_ready), 32'd0);
      end
      if (in_valid && in_ready) begin
        idx++;
        last_acc = cyc;
      end
      if (out_valid && out_ready) begin
        got_q.push_back({out_last, out_data});
        last_hs = cyc;
      end
      cyc++;
      @(negedge clk);
    end
    start_v   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (!done_seen) check("done_timeout", 32'(cyc), 32'd0);
    check("done_pulse_width", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic compare_vec(input vec_t v);
    check("n_outputs", 32'(got_q.size()), 32'(v.n_exp));
    for (int i = 0; i < int'(v.n_exp); i++)
      check($sformatf("vec_out%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF,
            32'(v.exp[i]));
  endtask

  task automatic compare_model();
    check("rnd_n_outputs", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rnd_out%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF,
            32'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start_v   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    sel       = '0;
    repeat (3) @(negedge clk);

    for (int s = 0; s < NDUT; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("rst_outs_dut%0d", s),
            {26'd0, busy, done, in_ready, out_valid, out_last, |out_data}, 32'd0);
    end
    rst = 1'b0;

`ifdef POOL_AVG_EN
    vecs[0] = mk(0, 0, 0,  4, 9'h002, 9'h004, 9'h00A, 9'h10C, 0, 0, 0, 0);
    vecs[1] = mk(0, 0, 10, 4, 9'h002, 9'h004, 9'h00A, 9'h10C, 0, 0, 0, 0);
    vecs[2] = mk(1, 0, 0,  4, 9'h003, 9'h005, 9'h00D, 9'h10F, 0, 0, 0, 0);
`else
    vecs[0] = mk(0, 0, 0,  4, 9'h005, 9'h007, 9'h00D, 9'h10F, 0, 0, 0, 0);
    vecs[1] = mk(0, 0, 10, 4, 9'h005, 9'h007, 9'h00D, 9'h10F, 0, 0, 0, 0);
    vecs[2] = mk(1, 0, 0,  4, 9'h006, 9'h008, 9'h010, 9'h112, 0, 0, 0, 0);
`endif
    vecs[3] = mk(2, 1, 0, 8, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h000, 9'h000, 9'h000, 9'h100);

    for (int v = 0; v < 4; v++) begin
      fill_pix(int'(vecs[v].sel), int'(vecs[v].pat));
      run_frame(int'(vecs[v].sel), int'(vecs[v].stall), 1'b0);
      compare_vec(vecs[v]);
    end

    // Abort a 4x4 frame after 6 pixels; the window ending at pixel 5 is already pending.
    begin
      int idx = 0;
      int guard = 0;
      int done_cnt = 0;
      fill_pix(0, 0);
      sel = 2'd0;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v = '0;
      while (idx < 6 && guard < 100) begin
        in_valid = 1'b1;
        in_data  = pix_q[idx];
        #1;
        if (in_ready) idx++;
        guard++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      check("ov_before_rst", 32'(out_valid), 32'd1);
      check("data_before_rst", 32'(out_data), `ifdef POOL_AVG_EN 32'd2 `else 32'd5 `endif);
      rst = 1'b1;
      @(negedge clk);
      check("abort_ov", 32'(out_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      check("abort_no_done", 32'(done_cnt), 32'd0);
      run_frame(0, 0, 1'b0);
      compare_vec(vecs[0]);
    end

    for (int r = 0; r < 12; r++) begin
      int s = r % NDUT;
      fill_pix(s, 2);
      model(s);
      run_frame(s, 0, 1'b1);
      compare_model();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
